// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package mem_arb_pkg;

    localparam logic        REQ_ID_FETCH = 1'b0;
    localparam logic        REQ_ID_LSU   = 1'b1;
    localparam int unsigned RD_LATENCY   = 2;

    typedef struct packed {
        logic valid;
        logic id;
    } inflight_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last accepted requester loses the next tie.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic [1:0] o_grant_c
);

    logic r_last_grant;

    always_comb begin
        o_grant_c = i_valid;
        if (i_valid == 2'b11) begin
            o_grant_c = (r_last_grant == REQ_ID_LSU) ? 2'b01 : 2'b10;
        end
    end

    // Reset to the LSU id so fetch wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= REQ_ID_LSU;
        end else if (i_accept) begin
            r_last_grant <= o_grant_c[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Front end for one shared RAM port: arbitrates two requesters, registers the
// RAM-side signals and routes each read response back to its issuer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    logic [1:0]            w_valid;
    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_sel_id;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    inflight_t             w_issue;
    inflight_t             w_retire;

    logic                  r_ram_wren;
    logic [ADDR_WIDTH-1:0] r_ram_address;
    logic [DATA_WIDTH-1:0] r_ram_data;
    inflight_t [RD_LATENCY-1:0] r_pipe;
    logic                  r_rsp0_valid;
    logic                  r_rsp1_valid;
    logic [DATA_WIDTH-1:0] r_rsp0_rdata;
    logic [DATA_WIDTH-1:0] r_rsp1_rdata;

    assign w_valid  = {req1_valid, req0_valid};
    assign w_accept = |(w_valid & w_grant);
    assign w_sel_id = w_grant[1];

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (w_valid),
        .i_accept  (w_accept),
        .o_grant_c (w_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    always_comb begin
        w_sel_we    = req0_we;
        w_sel_addr  = req0_addr;
        w_sel_wdata = req0_wdata;
        if (w_sel_id == REQ_ID_LSU) begin
            w_sel_we    = req1_we;
            w_sel_addr  = req1_addr;
            w_sel_wdata = req1_wdata;
        end
    end

    // RAM-side issue register; address/data hold when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_wren    <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
        end else begin
            r_ram_wren <= w_accept & w_sel_we;
            if (w_accept) begin
                r_ram_address <= w_sel_addr;
                r_ram_data    <= w_sel_wdata;
            end
        end
    end

    assign w_issue.valid = w_accept & ~w_sel_we;
    assign w_issue.id    = w_sel_id;
    assign w_retire      = r_pipe[RD_LATENCY-1];

    // In-flight read tracker; its last stage lines up with valid ram_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= {r_pipe[RD_LATENCY-2:0], w_issue};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_rsp0_valid <= w_retire.valid && (w_retire.id == REQ_ID_FETCH);
            r_rsp1_valid <= w_retire.valid && (w_retire.id == REQ_ID_LSU);
            if (w_retire.valid && (w_retire.id == REQ_ID_FETCH)) begin
                r_rsp0_rdata <= ram_q;
            end
            if (w_retire.valid && (w_retire.id == REQ_ID_LSU)) begin
                r_rsp1_rdata <= ram_q;
            end
        end
    end

    assign ram_wren    = r_ram_wren;
    assign ram_address = r_ram_address;
    assign ram_data    = r_ram_data;
    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_rdata  = r_rsp0_rdata;
    assign rsp1_rdata  = r_rsp1_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a behavioural
// one-cycle-latency RAM attached to the RAM port.
module tb_mem_port_arbiter;

    typedef struct {
        logic        v;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } chan_t;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [15:0] req0_addr = '0, req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [15:0] req1_addr = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_rdata, rsp1_rdata;
    logic        ram_wren;
    logic [15:0] ram_address, ram_data;
    logic [15:0] ram_q = '0;
    logic [15:0] mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    exp_t q0[$];
    exp_t q1[$];
    logic        exp_wren = 1'b0;
    logic [15:0] exp_addr = '0, exp_data = '0;
    logic [15:0] exp_rd0 = '0, exp_rd1 = '0;

    mem_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data),
        .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM: registered read, data valid one edge after the address is seen.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic chan_t rd(input logic [15:0] a, input logic [15:0] e);
        chan_t c;
        c.v = 1'b1; c.we = 1'b0; c.addr = a; c.wdata = 16'h0000; c.exp = e;
        return c;
    endfunction

    function automatic chan_t wr(input logic [15:0] a, input logic [15:0] d);
        chan_t c;
        c.v = 1'b1; c.we = 1'b1; c.addr = a; c.wdata = d; c.exp = 16'h0000;
        return c;
    endfunction

    function automatic chan_t nop();
        chan_t c;
        c.v = 1'b0; c.we = 1'b0; c.addr = 16'h0000; c.wdata = 16'h0000; c.exp = 16'h0000;
        return c;
    endfunction

    // One cycle of stimulus; exp_rdy is the hand-computed grant {req1,req0}.
    task automatic step(input chan_t c0, input chan_t c1, input logic [1:0] exp_rdy);
        chan_t       c;
        logic        nxt_wren;
        logic [15:0] nxt_addr, nxt_data;
        @(negedge clk);
        #1;
        req0_valid = c0.v; req0_we = c0.we; req0_addr = c0.addr; req0_wdata = c0.wdata;
        req1_valid = c1.v; req1_we = c1.we; req1_addr = c1.addr; req1_wdata = c1.wdata;
        #1;
        check("ready", {30'd0, req1_ready, req0_ready}, {30'd0, exp_rdy});
        nxt_wren = 1'b0;
        nxt_addr = exp_addr;
        nxt_data = exp_data;
        if (exp_rdy != 2'b00) begin
            c = exp_rdy[1] ? c1 : c0;
            nxt_wren = c.we;
            nxt_addr = c.addr;
            nxt_data = c.wdata;
            if (!c.we) begin
                if (exp_rdy[1]) q1.push_back('{c.exp, cyc + 3});
                else            q0.push_back('{c.exp, cyc + 3});
            end
        end
        @(posedge clk);
        #1;
        exp_wren = nxt_wren;
        exp_addr = nxt_addr;
        exp_data = nxt_data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(nop(), nop(), 2'b00);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        q0.delete();
        q1.delete();
        exp_wren = 1'b0; exp_addr = '0; exp_data = '0;
        exp_rd0 = '0; exp_rd1 = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: checks RAM-side registers and pops the scoreboard on responses.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic ev0, ev1;
        check("ram_wren", {31'd0, ram_wren}, {31'd0, exp_wren});
        check("ram_address", {16'd0, ram_address}, {16'd0, exp_addr});
        check("ram_data", {16'd0, ram_data}, {16'd0, exp_data});
        ev0 = (q0.size() != 0) && (q0[0].due == cyc);
        ev1 = (q1.size() != 0) && (q1[0].due == cyc);
        check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, ev0});
        check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, ev1});
        if (ev0) begin
            e = q0.pop_front();
            check("rsp0_rdata", {16'd0, rsp0_rdata}, {16'd0, e.data});
            exp_rd0 = e.data;
        end else begin
            check("rsp0_hold", {16'd0, rsp0_rdata}, {16'd0, exp_rd0});
        end
        if (ev1) begin
            e = q1.pop_front();
            check("rsp1_rdata", {16'd0, rsp1_rdata}, {16'd0, e.data});
            exp_rd1 = e.data;
        end else begin
            check("rsp1_hold", {16'd0, rsp1_rdata}, {16'd0, exp_rd1});
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0010] = 16'h1234;
        mem[16'h0100] = 16'hA001;
        mem[16'h0101] = 16'hA002;
        mem[16'h0200] = 16'hB001;
        mem[16'h0201] = 16'hB002;

        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(2);

        // Contention straight after reset: fetch first, then alternate.
        step(rd(16'h0100, 16'hA001), rd(16'h0200, 16'hB001), 2'b01);
        step(rd(16'h0101, 16'hA002), rd(16'h0200, 16'hB001), 2'b10);
        step(rd(16'h0101, 16'hA002), rd(16'h0201, 16'hB002), 2'b01);
        step(rd(16'h0010, 16'h1234), rd(16'h0201, 16'hB002), 2'b10);
        idle(4);

        // Single read from fetch.
        step(rd(16'h0010, 16'h1234), nop(), 2'b01);
        idle(4);

        // Write then immediate read-back on the LSU channel.
        step(nop(), wr(16'h00FF, 16'hBEEF), 2'b10);
        step(nop(), rd(16'h00FF, 16'hBEEF), 2'b10);
        idle(3);

        // Idle must not move the grant pointer (last winner was LSU).
        idle(5);
        step(rd(16'h0101, 16'hA002), rd(16'h0201, 16'hB002), 2'b01);
        step(nop(), rd(16'h0201, 16'hB002), 2'b10);
        idle(4);

        // Reset one edge after an accepted read drops the response.
        step(nop(), rd(16'h0200, 16'hB001), 2'b10);
        pulse_reset();
        idle(5);

        // Grant pointer back to its reset value.
        step(rd(16'h0010, 16'h1234), rd(16'h0201, 16'hB002), 2'b01);
        step(nop(), rd(16'h0201, 16'hB002), 2'b10);
        idle(5);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
